// File: rtl/action_dispatcher_pkg.sv
//------------------------------------------------------------------------------
// action_dispatcher_pkg : shared FSM encodings and constants for the dispatcher
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package action_dispatcher_pkg;

  localparam int AD_STATE_BUS = 3;

  typedef enum logic [AD_STATE_BUS-1:0] {
    AD_STATE_IDLE    = 3'd0,
    AD_STATE_LOOKUP  = 3'd1,
    AD_STATE_WAIT    = 3'd2,
    AD_STATE_RELEASE = 3'd3,
    AD_STATE_DONE    = 3'd4
  } ad_state_e;

  localparam int unsigned DEFAULT_ACTION_IDX = 0;
  localparam int unsigned RELEASE_CYCLES     = 2;

endpackage

`default_nettype wire

// File: rtl/action_dispatcher_sync_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with first-word-fall-through head output
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_push;
  logic w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/action_dispatcher.sv
//------------------------------------------------------------------------------
// action_dispatcher : buffers match results, resolves action addresses and
// drives the executor start/ready handshake with a watchdog. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module action_dispatcher
  import action_dispatcher_pkg::*;
#(
  parameter int ACTION_ID_W    = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   match_valid_i,
  output logic                   match_ready_o,
  input  logic                   match_hit_i,
  input  logic [ACTION_ID_W-1:0] match_action_id_i,
  input  logic [31:0]            match_args_addr_i,
  input  logic                   tbl_we_i,
  input  logic [ACTION_ID_W-1:0] tbl_waddr_i,
  input  logic [31:0]            tbl_wdata_i,
  output logic                   exec_start_o,
  output logic [31:0]            exec_start_addr_o,
  output logic [31:0]            exec_args_start_o,
  input  logic                   exec_ready_i,
  output logic                   done_valid_o,
  input  logic                   done_ready_i,
  output logic                   done_timeout_o
);

  localparam int unsigned ENTRIES = 2 ** ACTION_ID_W;
  localparam int unsigned FIFO_W  = 1 + ACTION_ID_W + 32;
  localparam int unsigned REL_W   = 2;

  logic [FIFO_W-1:0]      w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_head_hit;
  logic [ACTION_ID_W-1:0] w_head_id;
  logic [31:0]            w_head_args;
  logic [ACTION_ID_W-1:0] w_rd_idx;

  ad_state_e   state_q,      state_d;
  logic [31:0] args_lat_q,   args_lat_d;
  logic [31:0] start_addr_q, start_addr_d;
  logic [31:0] args_q,       args_d;
  logic        timeout_q,    timeout_d;
  logic [31:0] wait_cnt_q,   wait_cnt_d;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;

  logic [31:0] tbl_q [ENTRIES];
  logic [31:0] rd_data_q;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (match_valid_i),
    .wdata_i ({match_hit_i, match_action_id_i, match_args_addr_i}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_hit  = w_head[FIFO_W-1];
  assign w_head_id   = w_head[32 +: ACTION_ID_W];
  assign w_head_args = w_head[31:0];
  assign w_rd_idx    = w_head_hit ? w_head_id : ACTION_ID_W'(DEFAULT_ACTION_IDX);

  // Table is control-plane state and survives reset; read is read-first.
  always_ff @(posedge clk) begin
    if (tbl_we_i) tbl_q[tbl_waddr_i] <= tbl_wdata_i;
    if (w_pop)    rd_data_q          <= tbl_q[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= AD_STATE_IDLE;
      args_lat_q   <= '0;
      start_addr_q <= '0;
      args_q       <= '0;
      timeout_q    <= 1'b0;
      wait_cnt_q   <= '0;
      rel_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      args_lat_q   <= args_lat_d;
      start_addr_q <= start_addr_d;
      args_q       <= args_d;
      timeout_q    <= timeout_d;
      wait_cnt_q   <= wait_cnt_d;
      rel_cnt_q    <= rel_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    args_lat_d   = args_lat_q;
    start_addr_d = start_addr_q;
    args_d       = args_q;
    timeout_d    = timeout_q;
    wait_cnt_d   = wait_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    w_pop        = 1'b0;

    case (state_q)
      AD_STATE_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          args_lat_d = w_head_args;
          state_d    = AD_STATE_LOOKUP;
        end
      end
      AD_STATE_LOOKUP: begin
        start_addr_d = rd_data_q;
        args_d       = args_lat_q;
        wait_cnt_d   = '0;
        state_d      = AD_STATE_WAIT;
      end
      AD_STATE_WAIT: begin
        // Ready takes priority over the watchdog expiring in the same cycle.
        if (exec_ready_i) begin
          timeout_d = 1'b0;
          rel_cnt_d = '0;
          state_d   = AD_STATE_RELEASE;
        end else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          rel_cnt_d = '0;
          state_d   = AD_STATE_RELEASE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      AD_STATE_RELEASE: begin
        if (rel_cnt_q == REL_W'(RELEASE_CYCLES - 1)) begin
          state_d = AD_STATE_DONE;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      AD_STATE_DONE: begin
        if (done_ready_i) state_d = AD_STATE_IDLE;
      end
      default: state_d = AD_STATE_IDLE;
    endcase
  end

  assign match_ready_o     = !w_full;
  assign exec_start_o      = (state_q == AD_STATE_WAIT);
  assign exec_start_addr_o = start_addr_q;
  assign exec_args_start_o = args_q;
  assign done_valid_o      = (state_q == AD_STATE_DONE);
  assign done_timeout_o    = (state_q == AD_STATE_DONE) && timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_action_dispatcher.sv
//------------------------------------------------------------------------------
// tb_action_dispatcher : directed self-checking bench for action_dispatcher
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_action_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        match_valid_i;
  logic        match_ready_o;
  logic        match_hit_i;
  logic [3:0]  match_action_id_i;
  logic [31:0] match_args_addr_i;
  logic        tbl_we_i;
  logic [3:0]  tbl_waddr_i;
  logic [31:0] tbl_wdata_i;
  logic        exec_start_o;
  logic [31:0] exec_start_addr_o;
  logic [31:0] exec_args_start_o;
  logic        exec_ready_i;
  logic        done_valid_o;
  logic        done_ready_i;
  logic        done_timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  action_dispatcher #(
    .ACTION_ID_W    (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .match_valid_i     (match_valid_i),
    .match_ready_o     (match_ready_o),
    .match_hit_i       (match_hit_i),
    .match_action_id_i (match_action_id_i),
    .match_args_addr_i (match_args_addr_i),
    .tbl_we_i          (tbl_we_i),
    .tbl_waddr_i       (tbl_waddr_i),
    .tbl_wdata_i       (tbl_wdata_i),
    .exec_start_o      (exec_start_o),
    .exec_start_addr_o (exec_start_addr_o),
    .exec_args_start_o (exec_args_start_o),
    .exec_ready_i      (exec_ready_i),
    .done_valid_o      (done_valid_o),
    .done_ready_i      (done_ready_i),
    .done_timeout_o    (done_timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [3:0] idx, input logic [31:0] data);
    tbl_we_i = 1'b1; tbl_waddr_i = idx; tbl_wdata_i = data;
    tick();
    tbl_we_i = 1'b0;
  endtask

  task automatic push(input logic hit, input logic [3:0] id, input logic [31:0] args);
    match_valid_i = 1'b1; match_hit_i = hit; match_action_id_i = id; match_args_addr_i = args;
    tick();
    match_valid_i = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (!exec_start_o && n < budget) begin tick(); n++; end
    check(tag, exec_start_o, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_valid_o && n < budget) begin tick(); n++; end
    check(tag, done_valid_o, 1'b1);
  endtask

  task automatic pulse_ready();
    exec_ready_i = 1'b1;
    tick();
    exec_ready_i = 1'b0;
  endtask

  task automatic handshake();
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
  endtask

  logic [31:0] exp_addr [5];
  logic [31:0] exp_args [5];
  logic        bad;

  initial begin
    rst = 1'b1; match_valid_i = 1'b0; match_hit_i = 1'b0; match_action_id_i = '0;
    match_args_addr_i = '0; tbl_we_i = 1'b0; tbl_waddr_i = '0; tbl_wdata_i = '0;
    exec_ready_i = 1'b0; done_ready_i = 1'b0;
    tick(); tick();
    check("rst_ready", match_ready_o, 1'b1);
    check("rst_start", exec_start_o, 1'b0);
    check("rst_addr", exec_start_addr_o, 32'h0);
    check("rst_args", exec_args_start_o, 32'h0);
    check("rst_done", done_valid_o, 1'b0);
    check("rst_tmo", done_timeout_o, 1'b0);
    rst = 1'b0;

    tbl_write(4'd0, 32'h200);
    tbl_write(4'd3, 32'h100);
    tbl_write(4'd5, 32'h500);
    tbl_write(4'd6, 32'h600);
    tbl_write(4'd7, 32'h700);

    // Hit on entry 3: exact start latency and release timing
    push(1'b1, 4'd3, 32'h40);
    check("t1_start_e0", exec_start_o, 1'b0);
    tick();
    check("t1_start_e1", exec_start_o, 1'b0);
    tick();
    check("t1_start_e2", exec_start_o, 1'b1);
    check("t1_addr", exec_start_addr_o, 32'h100);
    check("t1_args", exec_args_start_o, 32'h40);
    pulse_ready();
    check("t1_start_drop", exec_start_o, 1'b0);
    check("t1_done_rel1", done_valid_o, 1'b0);
    tick();
    check("t1_done_rel2", done_valid_o, 1'b0);
    tick();
    check("t1_done", done_valid_o, 1'b1);
    check("t1_tmo", done_timeout_o, 1'b0);
    check("t1_addr_hold", exec_start_addr_o, 32'h100);
    handshake();
    check("t1_done_clr", done_valid_o, 1'b0);

    // Miss resolves through the default entry
    push(1'b0, 4'd3, 32'h80);
    wait_start("t2_start", 5);
    check("t2_addr", exec_start_addr_o, 32'h200);
    check("t2_args", exec_args_start_o, 32'h80);
    pulse_ready();
    wait_done("t2_done", 5);
    check("t2_tmo", done_timeout_o, 1'b0);
    handshake();

    // Five back-to-back results with a stalled executor
    exp_addr = '{32'h500, 32'h600, 32'h700, 32'h100, 32'h200};
    exp_args = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    push(1'b1, 4'd5, 32'h10);
    push(1'b1, 4'd6, 32'h20);
    push(1'b1, 4'd7, 32'h30);
    push(1'b1, 4'd3, 32'h40);
    check("t3_ready_4th", match_ready_o, 1'b1);
    push(1'b0, 4'd9, 32'h50);
    check("t3_ready_full", match_ready_o, 1'b0);
    push(1'b1, 4'd7, 32'hDEAD);
    check("t3_ready_ignored", match_ready_o, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("t3_start%0d", i), 8);
      check($sformatf("t3_addr%0d", i), exec_start_addr_o, exp_addr[i]);
      check($sformatf("t3_args%0d", i), exec_args_start_o, exp_args[i]);
      pulse_ready();
      wait_done($sformatf("t3_done%0d", i), 5);
      handshake();
    end
    check("t3_ready_after", match_ready_o, 1'b1);
    tick(); tick(); tick();
    check("t3_no_extra", exec_start_o, 1'b0);

    // Watchdog expiry after 8 WAIT cycles
    push(1'b1, 4'd6, 32'h99);
    wait_start("t4_start", 5);
    for (int i = 0; i < 7; i++) tick();
    check("t4_start_c7", exec_start_o, 1'b1);
    tick();
    check("t4_start_c8", exec_start_o, 1'b0);
    tick(); tick();
    check("t4_done", done_valid_o, 1'b1);
    check("t4_tmo", done_timeout_o, 1'b1);

    // Completion back-pressure with another result queued
    push(1'b1, 4'd7, 32'h77);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!done_valid_o || !done_timeout_o || exec_start_o ||
          exec_start_addr_o != 32'h600 || exec_args_start_o != 32'h99) bad = 1'b1;
      tick();
    end
    check("t5_stable", bad, 1'b0);
    handshake();
    check("t5_done_clr", done_valid_o, 1'b0);
    wait_start("t5_next_start", 4);
    check("t5_next_addr", exec_start_addr_o, 32'h700);
    check("t5_next_args", exec_args_start_o, 32'h77);

    // Reset during WAIT discards in-flight and buffered work
    push(1'b1, 4'd5, 32'h55);
    rst = 1'b1;
    tick();
    check("t6_start", exec_start_o, 1'b0);
    check("t6_ready", match_ready_o, 1'b1);
    check("t6_done", done_valid_o, 1'b0);
    check("t6_addr", exec_start_addr_o, 32'h0);
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("t6_fifo_empty", exec_start_o, 1'b0);

    // Table contents survive reset
    push(1'b1, 4'd3, 32'h33);
    wait_start("t7_start", 5);
    check("t7_addr", exec_start_addr_o, 32'h100);
    pulse_ready();
    wait_done("t7_done", 5);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
